mo_mul_pipe: RTL

Parametrised, handshaked Montgomery modular multiplier for the NTT/pointwise datapath. Computes c = a·b·R⁻¹ mod Q with R = 2^DATA_WIDTH on LANES independent lanes that share one valid/ready handshake. It is the successor to the fixed-width, free-running `mo_mul`: Q and width are generic, it supports backpressure, and final reduction to canonical form is optional.

---
 rtl/mo_mul_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mo_mul_pipe.sv
// mo_mul_pipe: handshaked, multi-lane Montgomery modular multiplier.
// Computes c = a*b*R^-1 mod Q with R = 2^DATA_WIDTH for LANES parallel lanes
// that share one valid/ready handshake and one set of stage valid bits.
//
// Build option:
//   MO_MUL_CANON_EN  defined   -> fourth stage subtracts Q once, c in [0,Q),
//                                 latency 4.
//                    undefined -> lazy result c = u in [0,2Q), latency 3.
//
// Pipeline per lane:
//   S1  t = a*b                              (2W bits)
//   S2  m = (t mod R)*QPRIME mod R, t carried
//   S3  u = (t + m*Q) >> W                   (W+1 bits, u < 2Q)
//   S4  c = (u >= Q) ? u-Q : u               (canonical build only)

module mo_mul_pipe #(
    parameter int Q          = 3329,
    parameter int DATA_WIDTH = 12,
    parameter int QPRIME     = 3327,
    parameter int LANES      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]     a,
    input  logic [LANES*DATA_WIDTH-1:0]     b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*(DATA_WIDTH+1)-1:0] c
);

    localparam int W  = DATA_WIDTH;
    localparam int UW = DATA_WIDTH + 1;

`ifdef MO_MUL_CANON_EN
    localparam int MUL_STAGE_CNT = 4;
`else
    localparam int MUL_STAGE_CNT = 3;
`endif

    localparam logic [W-1:0] Q_W      = W'(Q);
    localparam logic [W-1:0] QPRIME_W = W'(QPRIME);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipeline moves as one shift register gated by en; when the
    // last stage holds a result the consumer has not taken, everything
    // (including the input side) freezes, so in_ready = en. When the last
    // stage is empty the pipe advances regardless of out_ready, which lets
    // leading bubbles drain toward the output. Bubbles are never collapsed.
    logic                     en;
    logic [MUL_STAGE_CNT-1:0] vld;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld[MUL_STAGE_CNT-1];

    // Shared stage valid bits: shift in in_valid whenever the pipe advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[MUL_STAGE_CNT-2:0], in_valid};
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [W-1:0]   a_l;
        logic [W-1:0]   b_l;
        logic [2*W-1:0] prod;
        logic [W-1:0]   m_next;
        logic [2*W:0]   mq;
        logic [2*W:0]   sum;
        logic [UW-1:0]  u_next;

        logic [2*W-1:0] s1_t;
        logic [2*W-1:0] s2_t;
        logic [W-1:0]   s2_m;
        logic [UW-1:0]  s3_u;

        assign a_l = a[l*W +: W];
        assign b_l = b[l*W +: W];

        // Full-width product; zero-extend both operands so nothing truncates.
        assign prod = {{W{1'b0}}, a_l} * {{W{1'b0}}, b_l};

        // Evaluated at W bits, so the multiply wraps mod R by construction.
        assign m_next = s1_t[W-1:0] * QPRIME_W;

        // m*Q + t fits in 2W+1 bits; its low W bits are zero because
        // m was chosen so that t + m*Q == 0 mod R. Only the top W+1 bits
        // are kept.
        assign mq     = {{(W+1){1'b0}}, s2_m} * {{(W+1){1'b0}}, Q_W};
        assign sum    = {1'b0, s2_t} + mq;
        assign u_next = UW'(sum >> W);

        // S1: register the raw product. Data is captured even for bubbles;
        // only the shared valid bits say whether a slot is live.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_t <= '0;
            end else if (en) begin
                s1_t <= prod;
            end
        end

        // S2: compute the Montgomery quotient and carry the product along.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s2_t <= '0;
                s2_m <= '0;
            end else if (en) begin
                s2_t <= s1_t;
                s2_m <= m_next;
            end
        end

        // S3: reduced, lazy-form result u in [0,2Q).
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s3_u <= '0;
            end else if (en) begin
                s3_u <= u_next;
            end
        end

`ifdef MO_MUL_CANON_EN
        localparam logic [UW-1:0] Q_U = UW'(Q);

        logic [UW-1:0] c_next;
        logic [UW-1:0] s4_c;

        // One conditional subtraction is enough because u < 2Q.
        assign c_next = (s3_u >= Q_U) ? (s3_u - Q_U) : s3_u;

        // S4: canonical result register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s4_c <= '0;
            end else if (en) begin
                s4_c <= c_next;
            end
        end

        assign c[l*UW +: UW] = s4_c;
`else
        assign c[l*UW +: UW] = s3_u;
`endif
    end

endmodule
